// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: fetch-stage front end. Issues sequential instruction
// addresses over a valid/ready request channel, buffers in-order responses in
// a small FIFO tagged with their pc, and presents {instr, pc} to IF/ID.
// A redirect flushes the queue, marks in-flight requests stale and restarts
// fetch at the target.
//
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   mem_req_valid/ready/addr        instruction memory request channel
//   mem_rsp_valid/data              in-order response, no backpressure
//   redirect_valid/pc               flush and restart fetch
//   instr_valid/ready/data/pc       head of queue to IF/ID
//   err_unexpected_rsp              sticky: response with nothing in flight
module instr_prefetch_queue #(
    parameter int unsigned       ADDR_W   = 15,
    parameter int unsigned       INSTR_W  = 19,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_rsp_valid,
    input  logic [INSTR_W-1:0] mem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               err_unexpected_rsp
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] data;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  pc_rd_ptr_q, pc_rd_ptr_d;
    logic [PTR_W-1:0]  pc_wr_ptr_q, pc_wr_ptr_d;
    logic              err_q, err_d;

    entry_t            fifo_q    [DEPTH];
    logic [ADDR_W-1:0] pc_fifo_q [DEPTH];

    logic [SUM_W-1:0]  occupancy;
    logic              req_fire;
    logic              rsp_drop;
    logic              rsp_take;
    logic              rsp_err;
    logic              pop;
    logic              push;

    // Credit: buffered entries plus outstanding requests (stale included) bound issue.
    assign occupancy     = SUM_W'(count_q) + SUM_W'(inflight_q);
    assign mem_req_valid = (occupancy < SUM_W'(DEPTH)) && !redirect_valid && !reset;
    assign mem_req_addr  = fetch_pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign instr_valid        = (count_q != '0) && !redirect_valid;
    assign instr_data         = fifo_q[rd_ptr_q].data;
    assign instr_pc           = fifo_q[rd_ptr_q].pc;
    assign pop                = instr_valid && instr_ready;
    assign err_unexpected_rsp = err_q;

    // Response classification: stale responses retire first, in order.
    assign rsp_drop = mem_rsp_valid && (drop_cnt_q != '0);
    assign rsp_take = mem_rsp_valid && (drop_cnt_q == '0) && (inflight_q != '0);
    assign rsp_err  = mem_rsp_valid && (inflight_q == '0);
    assign push     = rsp_take && !redirect_valid;

    // Next-state logic.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        count_d     = count_q;
        inflight_d  = inflight_q;
        drop_cnt_d  = drop_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        pc_rd_ptr_d = pc_rd_ptr_q;
        pc_wr_ptr_d = pc_wr_ptr_q;
        err_d       = err_q || rsp_err;

        if (redirect_valid) begin
            // Everything still outstanding becomes stale; a response this cycle retires one.
            fetch_pc_d  = redirect_pc;
            count_d     = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            pc_rd_ptr_d = '0;
            pc_wr_ptr_d = '0;
            inflight_d  = inflight_q - CNT_W'(mem_rsp_valid && (inflight_q != '0));
            drop_cnt_d  = inflight_d;
        end else begin
            count_d    = count_q + CNT_W'(rsp_take) - CNT_W'(pop);
            inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_drop || rsp_take);
            drop_cnt_d = drop_cnt_q - CNT_W'(rsp_drop);
            if (rsp_take) begin
                wr_ptr_d    = wr_ptr_q + PTR_W'(1);
                pc_rd_ptr_d = pc_rd_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (req_fire) begin
                fetch_pc_d  = fetch_pc_q + ADDR_W'(1);
                pc_wr_ptr_d = pc_wr_ptr_q + PTR_W'(1);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            count_q     <= '0;
            inflight_q  <= '0;
            drop_cnt_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            pc_rd_ptr_q <= '0;
            pc_wr_ptr_q <= '0;
            err_q       <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            drop_cnt_q  <= drop_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            pc_rd_ptr_q <= pc_rd_ptr_d;
            pc_wr_ptr_q <= pc_wr_ptr_d;
            err_q       <= err_d;
        end
    end

    // Data storage: no reset, contents are qualified by count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{data: mem_rsp_data, pc: pc_fifo_q[pc_rd_ptr_q]};
        end
        if (req_fire) begin
            pc_fifo_q[pc_wr_ptr_q] <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomized bench for instr_prefetch_queue against a queue-based reference model,
// with a simple in-order memory model whose response data is a function of address.
module tb_instr_prefetch_queue;

    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned INSTR_W = 19;
    localparam int unsigned DEPTH   = 4;
    localparam int          DEPTH_I = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic               mem_rsp_valid;
    logic [INSTR_W-1:0] mem_rsp_data;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_pc;
    logic               err_unexpected_rsp;

    instr_prefetch_queue #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .RESET_PC(15'd0)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_addr      (mem_req_addr),
        .mem_rsp_valid     (mem_rsp_valid),
        .mem_rsp_data      (mem_rsp_data),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .instr_data        (instr_data),
        .instr_pc          (instr_pc),
        .err_unexpected_rsp(err_unexpected_rsp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [INSTR_W-1:0] data;
        logic [ADDR_W-1:0]  pc;
    } ent_t;

    // Reference model state
    ent_t              out_q[$];
    logic [ADDR_W-1:0] live_q[$];
    int                stale;
    logic [ADDR_W-1:0] m_pc;
    logic              m_err;

    // Memory model and observation
    logic [ADDR_W-1:0] mem_q[$];
    logic [ADDR_W-1:0] seen_pc[$];
    int                fires;
    int                pops;

    // Stimulus knobs
    logic              s_req_ready;
    logic              s_instr_ready;
    logic              s_redirect;
    logic [ADDR_W-1:0] s_redir_pc;
    logic              s_inject;
    int                s_rsp_pct;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [INSTR_W-1:0] mem_func(input logic [ADDR_W-1:0] a);
        logic [31:0] h;
        h = (32'(a) * 32'd40503) ^ 32'h0005_A5A5;
        return INSTR_W'(h);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        mem_req_ready  = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        s_req_ready    = 1'b0;
        s_instr_ready  = 1'b0;
        s_redirect     = 1'b0;
        s_redir_pc     = '0;
        s_inject       = 1'b0;
        s_rsp_pct      = 100;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_err", 32'(err_unexpected_rsp), 32'd0);
        out_q.delete();
        live_q.delete();
        mem_q.delete();
        seen_pc.delete();
        stale = 0;
        m_pc  = '0;
        m_err = 1'b0;
        fires = 0;
        pops  = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock cycle: drive at negedge, compare, then advance model to the next edge.
    task automatic step();
        logic exp_rv, exp_iv, fire, pop, rsp, injected;
        int   total;
        ent_t e;
        @(negedge clk);
        mem_req_ready  = s_req_ready;
        instr_ready    = s_instr_ready;
        redirect_valid = s_redirect;
        redirect_pc    = s_redir_pc;
        injected       = 1'b0;
        if (s_inject && mem_q.size() == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = INSTR_W'($urandom);
            injected      = 1'b1;
        end else if (mem_q.size() > 0 && int'($urandom_range(99)) < s_rsp_pct) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_func(mem_q[0]);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
        #1;
        exp_rv = ((out_q.size() + live_q.size() + stale) < DEPTH_I) && !s_redirect;
        exp_iv = (out_q.size() > 0) && !s_redirect;
        check("req_valid", 32'(mem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", 32'(mem_req_addr), 32'(m_pc));
        check("instr_valid", 32'(instr_valid), 32'(exp_iv));
        if (exp_iv) begin
            check("instr_pc", 32'(instr_pc), 32'(out_q[0].pc));
            check("instr_data", 32'(instr_data), 32'(out_q[0].data));
            check("data_vs_pc", 32'(instr_data), 32'(mem_func(instr_pc)));
        end
        check("err", 32'(err_unexpected_rsp), 32'(m_err));

        // Environment bookkeeping from observed handshakes
        if (mem_req_valid && mem_req_ready) begin
            fires++;
            mem_q.push_back(mem_req_addr);
        end
        if (instr_valid && instr_ready) begin
            pops++;
            seen_pc.push_back(instr_pc);
        end
        if (mem_rsp_valid && !injected) void'(mem_q.pop_front());

        // Reference model update
        fire = exp_rv && s_req_ready;
        pop  = exp_iv && s_instr_ready;
        rsp  = mem_rsp_valid;
        if (s_redirect) begin
            total = stale + live_q.size();
            if (rsp) begin
                if (total == 0) m_err = 1'b1;
                else total--;
            end
            stale = total;
            out_q.delete();
            live_q.delete();
            m_pc = s_redir_pc;
        end else begin
            if (pop) void'(out_q.pop_front());
            if (rsp) begin
                if (stale > 0) stale--;
                else if (live_q.size() > 0) begin
                    e.pc   = live_q.pop_front();
                    e.data = mem_rsp_data;
                    out_q.push_back(e);
                end else m_err = 1'b1;
            end
            if (fire) begin
                live_q.push_back(m_pc);
                m_pc = m_pc + ADDR_W'(1);
            end
        end
    endtask

    initial begin
        // Streaming: 1/cycle after startup
        do_reset();
        s_req_ready = 1'b1; s_instr_ready = 1'b1; s_rsp_pct = 100;
        repeat (4) step();
        fires = 0; pops = 0;
        repeat (16) step();
        check("stream_fires", 32'(fires), 32'd16);
        check("stream_pops", 32'(pops), 32'd16);

        // Backpressure: credit cap of DEPTH, one slot frees one request
        do_reset();
        s_req_ready = 1'b1; s_instr_ready = 1'b0; s_rsp_pct = 100;
        repeat (10) step();
        check("full_fires", 32'(fires), 32'd4);
        fires = 0;
        s_instr_ready = 1'b1;
        step();
        s_instr_ready = 1'b0;
        repeat (6) step();
        check("one_slot_fires", 32'(fires), 32'd1);

        // Redirect with two requests in flight
        do_reset();
        s_redirect = 1'b1; s_redir_pc = 15'd10;
        step();
        s_redirect = 1'b0; s_req_ready = 1'b1; s_rsp_pct = 0;
        repeat (2) step();
        s_req_ready = 1'b0;
        step();
        s_redirect = 1'b1; s_redir_pc = 15'h0200;
        step();
        s_redirect = 1'b0; s_req_ready = 1'b1; s_rsp_pct = 100; s_instr_ready = 1'b1;
        seen_pc.delete();
        repeat (12) step();
        check("redir_first_pc", 32'(seen_pc[0]), 32'h0200);
        check("redir_no_err", 32'(err_unexpected_rsp), 32'd0);

        // Address wrap
        do_reset();
        s_redirect = 1'b1; s_redir_pc = 15'h7FFE;
        step();
        s_redirect = 1'b0; s_req_ready = 1'b1; s_rsp_pct = 100; s_instr_ready = 1'b1;
        seen_pc.delete();
        repeat (10) step();
        check("wrap_pc0", 32'(seen_pc[0]), 32'h7FFE);
        check("wrap_pc1", 32'(seen_pc[1]), 32'h7FFF);
        check("wrap_pc2", 32'(seen_pc[2]), 32'h0000);
        check("wrap_pc3", 32'(seen_pc[3]), 32'h0001);

        // Unexpected response is sticky until reset
        do_reset();
        s_inject = 1'b1;
        step();
        s_inject = 1'b0;
        repeat (3) step();
        s_req_ready = 1'b1; s_instr_ready = 1'b1;
        repeat (6) step();
        check("err_sticky", 32'(err_unexpected_rsp), 32'd1);

        // Redirect coinciding with pop and response (count=2, inflight=1)
        do_reset();
        s_req_ready = 1'b1; s_instr_ready = 1'b0; s_rsp_pct = 100;
        repeat (3) step();
        s_redirect = 1'b1; s_redir_pc = 15'h0123; s_instr_ready = 1'b1;
        step();
        s_redirect = 1'b0;
        step();
        check("redir_pop_first_fire", 32'(fires), 32'd4);
        repeat (8) step();

        // Randomized traffic with redirects
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) s_rsp_pct = int'($urandom_range(20, 100));
            s_req_ready   = ($urandom_range(3) != 0);
            s_instr_ready = ($urandom_range(2) != 0);
            s_redirect    = ($urandom_range(19) == 0);
            if ($urandom_range(3) == 0) s_redir_pc = 15'h7FFC + ADDR_W'($urandom_range(3));
            else s_redir_pc = ADDR_W'($urandom);
            step();
        end
        s_redirect = 1'b0;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
Fetch-stage front end for the 19-bit pipelined core. It generates sequential instruction addresses and issues them to instruction memory over a valid/ready request channel. It buffers in-order memory responses in a small FIFO and hands {instruction, pc} to the IF/ID register through a valid/ready interface. A redirect from branch, jump, call or ret flushes the queue, discards in-flight responses and restarts fetch at the target.

Parameters:
ADDR_W, 15, instruction address width (wraps modulo 2^ADDR_W)
INSTR_W, 19, instruction word width
DEPTH, 4, FIFO entries; also the cap on entries plus in-flight requests (power of 2, >=2)
RESET_PC, 0, fetch address after reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
mem_req_valid  output  1  request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  ADDR_W  request address (= fetch_pc)
mem_rsp_valid  input  1  response valid (in order, no backpressure)
mem_rsp_data  input  INSTR_W  response instruction word
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  ADDR_W  restart address
instr_valid  output  1  head entry valid
instr_ready  input  1  consumer accepts head
instr_data  output  INSTR_W  head instruction
instr_pc  output  ADDR_W  address of head instruction
err_unexpected_rsp  output  1  sticky flag: response arrived with nothing in flight

Behaviour:
- Reset is asynchronous and active-high. It sets fetch_pc=RESET_PC; count, inflight, drop_cnt, rd/wr pointers and err_unexpected_rsp are set to 0. Consequently mem_req_valid=0 and instr_valid=0 while reset is asserted. FIFO data contents are don't-care.
- Internal state:
  - fetch_pc: next address to request.
  - inflight: accepted requests whose response is still pending, 0..DEPTH.
  - drop_cnt: the subset of inflight that is stale.
  - FIFO entries hold {data, pc}. A parallel pc FIFO holds the address of each live in-flight request.
- Issue:
  - mem_req_valid = (count + inflight < DEPTH) && !redirect_valid. This is combinational.
  - Fire = mem_req_valid && mem_req_ready. On fire: fetch_pc <= fetch_pc+1 (wraps 2^ADDR_W-1 -> 0), inflight++, and fetch_pc is pushed to the pc FIFO.
  - A request held without ready keeps the same address.
- Response:
  - If drop_cnt>0: the response is discarded; drop_cnt-- and inflight--.
  - Else if inflight>0: {mem_rsp_data, pc-FIFO head} is written to the FIFO; count++ and inflight--.
  - Else: the response is ignored and err_unexpected_rsp <= 1. It stays 1 until reset.
- Output:
  - instr_valid = (count>0) && !redirect_valid.
  - instr_data/instr_pc = head entry.
  - Pop when instr_valid && instr_ready.
  - There is zero bypass: a response is visible at the output the cycle after it arrives (1-cycle min latency mem_rsp -> instr_valid).
- Simultaneous events in a normal cycle: push, pop, issue and response in the same cycle are all legal. count and inflight are updated by net increment/decrement and never exceed DEPTH.
- Redirect cycle (redirect_valid=1):
  - No issue, no pop. instr_valid and mem_req_valid are forced low.
  - Next cycle: count=0, pointers reset, pc FIFO cleared, fetch_pc=redirect_pc.
  - drop_cnt <= inflight - (1 if a response arrives this cycle).
  - inflight <= the same value.
  - A response arriving in the redirect cycle is discarded.
  - Back-to-back redirects: the last one wins, and drop accounting remains consistent.
  - Issue resumes the cycle after redirect, provided count+inflight<DEPTH. Stale in-flight requests still consume credit until their responses return.
- Full: with count+inflight=DEPTH, mem_req_valid=0. Issue resumes the cycle after a pop or a dropped response frees a slot.
- Empty: instr_valid=0 and instr_data/instr_pc hold their last values (don't-care).
- Reset mid-operation: any outstanding memory responses after reset deassertion hit the error path. The integration must reset memory together with this block.

Test Plan:
1. Reset, mem_req_ready=1, 1-cycle memory latency, instr_ready=1 -> addresses 0,1,2,... issued every cycle; instr_pc 0,1,2 with matching data; throughput 1/cycle after 2-cycle startup.
2. instr_ready=0, memory always ready -> exactly 4 requests (0..3) issued, then mem_req_valid=0. Release instr_ready for 1 cycle -> exactly one new request (addr 4).
3. Two requests in flight (addrs 10, 11); redirect_pc=0x0200 asserted -> both responses dropped, never appear at output. First instr_valid has instr_pc=0x0200. err_unexpected_rsp stays 0.
4. Redirect to 0x7FFE -> instr_pc sequence 0x7FFE, 0x7FFF, 0x0000, 0x0001.
5. mem_rsp_valid pulsed with inflight=0 -> err_unexpected_rsp=1 and stays 1; FIFO count unchanged; cleared only by reset.
6. Redirect asserted in the same cycle as a pop and a response (count=2, inflight=1) -> no pop recorded. Next cycle count=0, inflight=0, drop_cnt=0, mem_req_addr=redirect_pc.
